// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared types and constants for the unified-port bus arbiter.
// Holds the arbiter state encoding, the byte-lane type, the all-lanes constant
// used for instruction fetches, and the one-hot grant record.
package bus_arbiter_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_SEL_W  = 4;

    typedef logic [BUS_SEL_W-1:0] bus_sel_t;

    // Fetches always read a full word.
    localparam bus_sel_t BUS_SEL_ALL = 4'hF;

    // Arbiter states: idle, fetch cycle, data cycle, aborted fetch draining.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IF_XFER  = 2'd1,
        ST_MEM_XFER = 2'd2,
        ST_DISCARD  = 2'd3
    } arb_state_e;

    // Identity of a requester, used as the last-grant marker.
    typedef enum logic {
        REQ_IF  = 1'b0,
        REQ_MEM = 1'b1
    } requester_e;

    // One-hot grant produced by the grant picker.
    typedef struct packed {
        logic if_gnt;
        logic mem_gnt;
    } grant_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: bundles the fetch requester, data requester, flush, stall
// and Wishbone-style memory port signals. The master modport is the arbiter's
// view (it masters the memory bus); the slave modport is the environment's
// view (requesters, pipeline control and the memory).
interface bus_arbiter_if
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
) ();

    // Instruction-fetch requester
    logic                 if_req_i;
    logic [ADDR_W-1:0]    if_addr_i;
    logic [DATA_W-1:0]    if_rdata_o;
    logic                 if_ack_o;

    // Data-access requester
    logic                 mem_req_i;
    logic                 mem_we_i;
    logic [BUS_SEL_W-1:0] mem_sel_i;
    logic [ADDR_W-1:0]    mem_addr_i;
    logic [DATA_W-1:0]    mem_wdata_i;
    logic [DATA_W-1:0]    mem_rdata_o;
    logic                 mem_ack_o;

    // Pipeline control
    logic                 flush_i;
    logic                 stallreq_if_o;
    logic                 stallreq_mem_o;

    // Shared memory port
    logic                 bus_cyc_o;
    logic                 bus_stb_o;
    logic                 bus_we_o;
    logic [BUS_SEL_W-1:0] bus_sel_o;
    logic [ADDR_W-1:0]    bus_addr_o;
    logic [DATA_W-1:0]    bus_wdata_o;
    logic [DATA_W-1:0]    bus_rdata_i;
    logic                 bus_ack_i;

    modport master (
        input  if_req_i, if_addr_i,
        output if_rdata_o, if_ack_o,
        input  mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
        output mem_rdata_o, mem_ack_o,
        input  flush_i,
        output stallreq_if_o, stallreq_mem_o,
        output bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
        input  bus_rdata_i, bus_ack_i
    );

    modport slave (
        output if_req_i, if_addr_i,
        input  if_rdata_o, if_ack_o,
        output mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
        input  mem_rdata_o, mem_ack_o,
        output flush_i,
        input  stallreq_if_o, stallreq_mem_o,
        input  bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
        output bus_rdata_i, bus_ack_i
    );

endinterface

// File: rtl/bus_arb_grant.sv
// bus_arb_grant: combinational grant picker for the bus arbiter.
// A requester whose ack is high this cycle is masked so a held request is not
// granted twice; a fetch is masked while flush is high.
// Build option BUS_ARB_RR_EN: round-robin on contention using the last-grant
// marker. Without it, the data requester always wins and no marker exists.
module bus_arb_grant
    import bus_arbiter_pkg::*;
(
    input  logic       i_if_req,
    input  logic       i_mem_req,
    input  logic       i_if_ack,
    input  logic       i_mem_ack,
    input  logic       i_flush,
`ifdef BUS_ARB_RR_EN
    input  requester_e i_last_grant,
`endif
    output grant_t     o_grant
);

    logic w_if_ok;
    logic w_mem_ok;

    assign w_if_ok  = i_if_req & ~i_if_ack & ~i_flush;
    assign w_mem_ok = i_mem_req & ~i_mem_ack;

    // Pick at most one requester among the eligible ones.
    always_comb begin
        // NOTE: default every output first so no path leaves it unassigned (no latch).
        o_grant = '0;
`ifdef BUS_ARB_RR_EN
        if (w_if_ok && w_mem_ok) begin
            if (i_last_grant == REQ_MEM) begin
                o_grant.if_gnt = 1'b1;
            end else begin
                o_grant.mem_gnt = 1'b1;
            end
        end else begin
            o_grant.if_gnt  = w_if_ok;
            o_grant.mem_gnt = w_mem_ok;
        end
`else
        o_grant.mem_gnt = w_mem_ok;
        o_grant.if_gnt  = w_if_ok & ~w_mem_ok;
`endif
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one Wishbone-style memory port between the fetch (PC)
// and data (MEM) requesters. Serialises bus cycles, returns read data with a
// one-cycle ack to the granted requester, raises stall requests while a
// request is outstanding, and lets flush abort a fetch without breaking the
// bus cycle (the cycle drains in DISCARD with no ack).
// Build option BUS_ARB_RR_EN: round-robin arbitration with a last-grant
// marker; default build is fixed priority with the data requester first.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.master bus
);

    arb_state_e        r_state;
    arb_state_e        w_state_next;
    grant_t            w_grant;

    logic              w_load_if;
    logic              w_load_mem;
    logic              w_if_done;
    logic              w_mem_done;

    logic              r_bus_we;
    bus_sel_t          r_bus_sel;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_mem_rdata;
    logic              r_if_ack;
    logic              r_mem_ack;

`ifdef BUS_ARB_RR_EN
    requester_e        r_last_grant;
`endif

    bus_arb_grant u_grant (
        .i_if_req     (bus.if_req_i),
        .i_mem_req    (bus.mem_req_i),
        .i_if_ack     (r_if_ack),
        .i_mem_ack    (r_mem_ack),
        .i_flush      (bus.flush_i),
`ifdef BUS_ARB_RR_EN
        .i_last_grant (r_last_grant),
`endif
        .o_grant      (w_grant)
    );

    // State register; reset drops any bus cycle immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus grant-load and completion strobes.
    always_comb begin
        w_state_next = r_state;
        w_load_if    = 1'b0;
        w_load_mem   = 1'b0;
        w_if_done    = 1'b0;
        w_mem_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant.mem_gnt) begin
                    w_state_next = ST_MEM_XFER;
                    w_load_mem   = 1'b1;
                end else if (w_grant.if_gnt) begin
                    w_state_next = ST_IF_XFER;
                    w_load_if    = 1'b1;
                end
            end
            ST_IF_XFER: begin
                if (bus.bus_ack_i) begin
                    // A flush arriving with the ack still suppresses delivery.
                    w_state_next = ST_IDLE;
                    w_if_done    = ~bus.flush_i;
                end else if (bus.flush_i) begin
                    w_state_next = ST_DISCARD;
                end
            end
            ST_MEM_XFER: begin
                if (bus.bus_ack_i) begin
                    w_state_next = ST_IDLE;
                    w_mem_done   = 1'b1;
                end
            end
            ST_DISCARD: begin
                if (bus.bus_ack_i) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Bus request registers, read-data capture and one-cycle ack pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: data registers are reset too because every output must read 0 during reset.
            r_bus_we    <= 1'b0;
            r_bus_sel   <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
            r_if_ack    <= 1'b0;
            r_mem_ack   <= 1'b0;
        end else begin
            r_if_ack  <= w_if_done;
            r_mem_ack <= w_mem_done;
            if (w_load_mem) begin
                r_bus_we    <= bus.mem_we_i;
                r_bus_sel   <= bus.mem_sel_i;
                r_bus_addr  <= bus.mem_addr_i;
                r_bus_wdata <= bus.mem_wdata_i;
            end else if (w_load_if) begin
                r_bus_we    <= 1'b0;
                r_bus_sel   <= BUS_SEL_ALL;
                r_bus_addr  <= bus.if_addr_i;
                r_bus_wdata <= '0;
            end
            if (w_if_done) begin
                r_if_rdata <= bus.bus_rdata_i;
            end
            if (w_mem_done) begin
                r_mem_rdata <= bus.bus_rdata_i;
            end
        end
    end

`ifdef BUS_ARB_RR_EN
    // Last-grant marker, updated on every grant; starts as the fetch side.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= REQ_IF;
        end else if (w_load_mem) begin
            r_last_grant <= REQ_MEM;
        end else if (w_load_if) begin
            r_last_grant <= REQ_IF;
        end
    end
`endif

    // The bus cycle is open in every state except IDLE, including DISCARD.
    assign bus.bus_cyc_o   = (r_state != ST_IDLE);
    assign bus.bus_stb_o   = (r_state != ST_IDLE);
    assign bus.bus_we_o    = r_bus_we;
    assign bus.bus_sel_o   = r_bus_sel;
    assign bus.bus_addr_o  = r_bus_addr;
    assign bus.bus_wdata_o = r_bus_wdata;

    assign bus.if_rdata_o  = r_if_rdata;
    assign bus.if_ack_o    = r_if_ack;
    assign bus.mem_rdata_o = r_mem_rdata;
    assign bus.mem_ack_o   = r_mem_ack;

    // Stall while a request is pending and not being acknowledged this cycle.
    assign bus.stallreq_if_o  = bus.if_req_i & ~r_if_ack;
    assign bus.stallreq_mem_o = bus.mem_req_i & ~r_mem_ack;

endmodule
